// File: rtl/tick_debouncer.sv
// tick_debouncer: tick-sampled button debouncer with press/release/long-press strobes
module tick_debouncer #(
    parameter int unsigned STABLE_TICKS = 3,
    parameter int unsigned LONG_TICKS = 60,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_in,
    output logic btn_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);
    localparam int DW = $clog2(STABLE_TICKS + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);
    typedef enum logic [1:0] {RELEASED, RISE_WAIT, PRESSED, FALL_WAIT} state_t;
    state_t state;
    logic [1:0] sync;
    logic [DW-1:0] deb;
    logic [HW-1:0] hold;
    logic s;
    logic deb_done;
    assign s = sync[1] ^ ACTIVE_LOW;
    assign deb_done = deb == DW'(STABLE_TICKS - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= {2{ACTIVE_LOW}};
            state <= RELEASED;
            deb <= '0;
            hold <= '0;
            btn_state <= 1'b0;
            press_pulse <= 1'b0;
            release_pulse <= 1'b0;
            long_press <= 1'b0;
        end else begin
            sync <= {sync[0], btn_in};
            press_pulse <= 1'b0;
            release_pulse <= 1'b0;
            long_press <= 1'b0;
            case (state)
                RELEASED: if (s) begin
                    state <= RISE_WAIT;
                    deb <= '0;
                end
                RISE_WAIT: if (!s) begin
                    state <= RELEASED;
                    deb <= '0;
                end else if (tick) begin
                    if (deb_done) begin
                        state <= PRESSED;
                        deb <= '0;
                        btn_state <= 1'b1;
                        press_pulse <= 1'b1;
                    end else deb <= deb + 1'b1;
                end
                // hold saturates at LONG_TICKS, so long_press fires only on that one increment
                PRESSED: if (!s) begin
                    state <= FALL_WAIT;
                    deb <= '0;
                end else if (tick && hold != HW'(LONG_TICKS)) begin
                    hold <= hold + 1'b1;
                    long_press <= hold == HW'(LONG_TICKS - 1);
                end
                FALL_WAIT: if (s) begin
                    state <= PRESSED;
                    deb <= '0;
                end else if (tick) begin
                    if (deb_done) begin
                        state <= RELEASED;
                        deb <= '0;
                        hold <= '0;
                        btn_state <= 1'b0;
                        release_pulse <= 1'b1;
                    end else deb <= deb + 1'b1;
                end
                default: state <= RELEASED;
            endcase
        end
    end
endmodule

// File: tb/tb_tick_debouncer.sv
// tb_tick_debouncer: directed checks of debounce, long press, abort priority and reset
module tb_tick_debouncer;
    logic clk = 1'b0, rst = 1'b1, tick = 1'b0;
    logic btn_a = 1'b0, btn_b = 1'b0, btn_c = 1'b1;
    logic st_a, pp_a, rp_a, lp_a, st_b, pp_b, rp_b, lp_b, st_c, pp_c, rp_c, lp_c;
    int n_tests = 0, n_fail = 0;
    int np_a = 0, nr_a = 0, nl_a = 0, np_c = 0, nr_c = 0;
    int p0, r0, l0, pc0, rc0;
    always #5 clk = ~clk;
    tick_debouncer #(.STABLE_TICKS(3), .LONG_TICKS(8), .ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .btn_in(btn_a),
        .btn_state(st_a), .press_pulse(pp_a), .release_pulse(rp_a), .long_press(lp_a)
    );
    tick_debouncer #(.STABLE_TICKS(1), .LONG_TICKS(2), .ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .btn_in(btn_b),
        .btn_state(st_b), .press_pulse(pp_b), .release_pulse(rp_b), .long_press(lp_b)
    );
    tick_debouncer #(.STABLE_TICKS(3), .LONG_TICKS(8), .ACTIVE_LOW(1'b1)) dut_c (
        .clk(clk), .rst(rst), .tick(tick), .btn_in(btn_c),
        .btn_state(st_c), .press_pulse(pp_c), .release_pulse(rp_c), .long_press(lp_c)
    );
    always @(negedge clk) begin
        np_a += int'(pp_a);
        nr_a += int'(rp_a);
        nl_a += int'(lp_a);
        np_c += int'(pp_c);
        nr_c += int'(rp_c);
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic cyc(input logic t);
        tick = t;
        @(posedge clk);
        #1;
    endtask
    task automatic tk();
        repeat (3) cyc(1'b0);
        cyc(1'b1);
    endtask
    task automatic settle();
        repeat (3) cyc(1'b0);
    endtask
    initial begin
        rst = 1'b1;
        btn_a = 1'b1;
        repeat (3) cyc(1'b1);
        check("rst_state", 32'(st_a), 0);
        check("rst_press", 32'(pp_a), 0);
        check("rst_state_c", 32'(st_c), 0);
        btn_a = 1'b0;
        cyc(1'b0);
        rst = 1'b0;
        cyc(1'b0);
        p0 = np_a; r0 = nr_a; l0 = nl_a;
        btn_a = 1'b1;
        settle(); tk(); tk();
        check("press_early", 32'(st_a), 0);
        repeat (3) cyc(1'b0);
        check("press_before_tick3", 32'(st_a), 0);
        cyc(1'b1);
        check("press_state", 32'(st_a), 1);
        check("press_pulse", 32'(pp_a), 1);
        cyc(1'b0);
        check("press_width", 32'(pp_a), 0);
        check("press_count", 32'(np_a - p0), 1);
        check("press_no_release", 32'(nr_a - r0), 0);
        repeat (7) tk();
        cyc(1'b0);
        check("long_early", 32'(nl_a - l0), 0);
        repeat (2) cyc(1'b0);
        cyc(1'b1);
        check("long_pulse", 32'(lp_a), 1);
        cyc(1'b0);
        check("long_width", 32'(lp_a), 0);
        repeat (20) tk();
        cyc(1'b0);
        check("long_once", 32'(nl_a - l0), 1);
        r0 = nr_a;
        btn_a = 1'b0;
        settle(); tk();
        btn_a = 1'b1;
        settle();
        check("glitch_state", 32'(st_a), 1);
        repeat (10) tk();
        cyc(1'b0);
        check("glitch_no_release", 32'(nr_a - r0), 0);
        check("glitch_no_rearm", 32'(nl_a - l0), 1);
        btn_a = 1'b0;
        settle(); tk(); tk();
        check("release_early", 32'(st_a), 1);
        tk();
        check("release_state", 32'(st_a), 0);
        check("release_pulse", 32'(rp_a), 1);
        cyc(1'b0);
        check("release_width", 32'(rp_a), 0);
        check("release_count", 32'(nr_a - r0), 1);
        p0 = np_a;
        btn_a = 1'b1; settle(); tk();
        btn_a = 1'b0; settle();
        btn_a = 1'b1; settle(); tk();
        btn_a = 1'b0; settle();
        btn_a = 1'b1; settle(); tk(); tk();
        check("bounce_hold", 32'(st_a), 0);
        check("bounce_no_press", 32'(np_a - p0), 0);
        tk();
        check("bounce_press", 32'(pp_a), 1);
        cyc(1'b0);
        check("bounce_press_count", 32'(np_a - p0), 1);
        repeat (7) tk();
        check("long_rearm_early", 32'(lp_a), 0);
        tk();
        check("long_rearm", 32'(lp_a), 1);
        btn_a = 1'b0;
        settle(); tk(); tk(); tk(); cyc(1'b0);
        check("abort_released", 32'(st_a), 0);
        btn_a = 1'b1;
        settle(); tk(); tk();
        btn_a = 1'b0;
        cyc(1'b0); cyc(1'b0); cyc(1'b1);
        check("abort_state", 32'(st_a), 0);
        btn_a = 1'b1;
        settle(); tk(); tk();
        check("abort_cleared", 32'(st_a), 0);
        tk();
        check("abort_repress", 32'(st_a), 1);
        btn_b = 1'b1;
        repeat (3) cyc(1'b1);
        check("fast_early", 32'(st_b), 0);
        cyc(1'b1);
        check("fast_press", 32'(pp_b), 1);
        check("fast_state", 32'(st_b), 1);
        check("fast_no_release", 32'(rp_b), 0);
        cyc(1'b1);
        check("fast_width", 32'(pp_b), 0);
        check("fast_long_early", 32'(lp_b), 0);
        cyc(1'b1);
        check("fast_long", 32'(lp_b), 1);
        btn_b = 1'b0;
        check("c_idle", 32'(st_c), 0);
        pc0 = np_c;
        btn_c = 1'b0;
        settle(); tk(); tk(); tk(); cyc(1'b0);
        check("pre_rst_a", 32'(st_a), 1);
        check("pre_rst_c", 32'(st_c), 1);
        check("c_press_count", 32'(np_c - pc0), 1);
        check("c_no_long", 32'(lp_c), 0);
        p0 = np_a; r0 = nr_a; pc0 = np_c; rc0 = nr_c;
        rst = 1'b1;
        cyc(1'b1); cyc(1'b1);
        check("rst_mid_a", 32'(st_a), 0);
        check("rst_mid_c", 32'(st_c), 0);
        check("rst_mid_release", 32'(rp_a), 0);
        rst = 1'b0;
        settle(); tk(); tk();
        check("rst_redebounce_a", 32'(st_a), 0);
        check("rst_redebounce_c", 32'(st_c), 0);
        tk();
        check("rst_repress_a", 32'(pp_a), 1);
        check("rst_repress_c", 32'(pp_c), 1);
        cyc(1'b0);
        check("rst_no_release_a", 32'(nr_a - r0), 0);
        check("rst_no_release_c", 32'(nr_c - rc0), 0);
        check("rst_press_count_a", 32'(np_a - p0), 1);
        check("rst_press_count_c", 32'(np_c - pc0), 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
